mem_responder_bram: RTL and testbench

- On-chip BRAM responder for the memory-controller request interface used by the RV DRAM front-end: read_a/read_b/write/refresh, addr/din/mask, a busy handshake, and dout_a/dout_b.
- Drop-in substitute for the SDRAM controller in simulation and on boards without SDRAM.
- Services one request at a time with configurable latency.
- Reproduces the busy rise/fall protocol that the front-end state machine depends on.

---
 rtl/mem_responder_bram.sv | 176 +++++++++++++++++
 tb/tb_mem_responder_bram.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder_bram.sv
// On-chip BRAM stand-in for the SDRAM controller request interface: one request at a time,
// fixed busy latencies. Optional refresh-interval watchdog under `MEMRESP_REFRESH_CHECK_EN.
module mem_responder_bram #(
  parameter int ADDR_WIDTH  = 14,
  parameter int RD_LATENCY  = 2,
  parameter int WR_LATENCY  = 1,
  parameter int REF_CYCLES  = 4,
  parameter int INIT_CYCLES = 16,
  parameter int REF_LIMIT   = 405
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_a,
  input  logic        read_b,
  input  logic        write,
  input  logic        refresh,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mask,
  output logic [31:0] dout_a,
  output logic [31:0] dout_b,
  output logic        busy,
  output logic        mem_initialized,
  output logic        fail
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [1:0] {K_READ_A, K_READ_B, K_WRITE, K_REFRESH} kind_t;

  state_t r_state, w_state_nxt;
  kind_t  r_kind, w_kind;

  logic [31:0]           r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [31:0]           r_din;
  logic [3:0]            r_mask;
  logic [31:0]           r_rd_word;
  logic [31:0]           r_mem [0:DEPTH-1];

  logic                  w_req_any;
  logic                  w_accept;
  logic                  w_oob;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_lat;
  logic                  w_init_last;
  logic                  w_busy_last;
  logic                  w_do_write;
  logic                  w_ref_err;
  logic [1:0]            w_unused_addr_lsbs;

  assign w_req_any          = refresh | write | read_a | read_b;
  assign w_accept           = (r_state == S_IDLE) && w_req_any;
  assign w_idx              = addr[ADDR_WIDTH+1:2];
  assign w_oob              = |addr[31:ADDR_WIDTH+2];
  assign w_unused_addr_lsbs = addr[1:0];
  assign w_init_last        = (r_cnt == 32'(INIT_CYCLES - 1));
  assign w_busy_last        = (r_cnt == 32'd1);
  // The write lands on the first BUSY edge, while the counter still holds its load value.
  assign w_do_write         = (r_state == S_BUSY) && (r_kind == K_WRITE) &&
                              (r_cnt == 32'(WR_LATENCY));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_kind = K_READ_B;
    w_lat  = 32'(RD_LATENCY);
    if (refresh) begin
      w_kind = K_REFRESH;
      w_lat  = 32'(REF_CYCLES);
    end else if (write) begin
      w_kind = K_WRITE;
      w_lat  = 32'(WR_LATENCY);
    end else if (read_a) begin
      w_kind = K_READ_A;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= S_INIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT:  if (w_init_last) w_state_nxt = S_IDLE;
      S_IDLE:  if (w_accept)    w_state_nxt = S_BUSY;
      S_BUSY:  if (w_busy_last) w_state_nxt = S_DONE;
      S_DONE:                   w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy            <= 1'b1;
      mem_initialized <= 1'b0;
      fail            <= 1'b0;
      dout_a          <= '0;
      dout_b          <= '0;
      r_cnt           <= '0;
      r_kind          <= K_REFRESH;
      r_idx           <= '0;
      r_din           <= '0;
      r_mask          <= '1;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_init_last) begin
            r_cnt           <= '0;
            busy            <= 1'b0;
            mem_initialized <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_IDLE: begin
          if (w_accept) begin
            r_kind <= w_kind;
            r_idx  <= w_idx;
            r_din  <= din;
            r_mask <= mask;
            r_cnt  <= w_lat;
            busy   <= 1'b1;
          end
        end
        S_BUSY: begin
          if (w_busy_last) begin
            r_cnt <= '0;
            busy  <= 1'b0;
            if (r_kind == K_READ_A) dout_a <= r_rd_word;
            if (r_kind == K_READ_B) dout_b <= r_rd_word;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: ;
      endcase
      if ((w_accept && (w_kind != K_REFRESH) && w_oob) || w_ref_err) fail <= 1'b1;
    end
  end

  // NOTE: the array has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_accept && (w_kind == K_READ_A || w_kind == K_READ_B)) r_rd_word <= r_mem[w_idx];
    if (w_do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (!r_mask[b]) r_mem[r_idx][8*b +: 8] <= r_din[8*b +: 8];
      end
    end
  end

`ifdef MEMRESP_REFRESH_CHECK_EN
  logic [31:0] r_ref_cnt;

  // Counts from INIT exit (held at zero until then) and restarts on each accepted refresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt <= '0;
    end else if (!mem_initialized || (w_accept && w_kind == K_REFRESH)) begin
      r_ref_cnt <= '0;
    end else if (r_ref_cnt != '1) begin
      r_ref_cnt <= r_ref_cnt + 32'd1;
    end
  end

  assign w_ref_err = mem_initialized && (r_ref_cnt > 32'(REF_LIMIT));
`else
  logic [31:0] w_unused_ref_limit;
  assign w_unused_ref_limit = 32'(REF_LIMIT);
  assign w_ref_err          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder_bram.sv
// Directed bench for mem_responder_bram: read results are scoreboarded against a byte-masked
// reference memory and compared when busy falls.
module tb_mem_responder_bram;

  localparam int AW = 14;
`ifdef MEMRESP_REFRESH_CHECK_EN
  localparam logic LATE_REF_FAIL = 1'b1;
`else
  localparam logic LATE_REF_FAIL = 1'b0;
`endif

  typedef enum {K_RA, K_RB, K_WR, K_RF} kind_e;
  typedef struct {bit port_b; logic [31:0] data;} exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_a, read_b, write, refresh;
  logic [31:0] addr, din;
  logic [3:0]  mask;
  logic [31:0] dout_a, dout_b;
  logic        busy, mem_initialized, fail;

  exp_t        sb[$];
  logic [31:0] model [int];
  logic [31:0] exp_a, exp_b;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;

  mem_responder_bram #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .read_a(read_a), .read_b(read_b), .write(write),
    .refresh(refresh), .addr(addr), .din(din), .mask(mask), .dout_a(dout_a),
    .dout_b(dout_b), .busy(busy), .mem_initialized(mem_initialized), .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & ((32'd1 << AW) - 32'd1));
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] w;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'hxxxx_xxxx;
    for (int b = 0; b < 4; b++) if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
    model[widx(a)] = w;
  endfunction

  task automatic push_read(input bit port_b, input logic [31:0] a);
    exp_t e;
    e.port_b = port_b;
    e.data   = model[widx(a)];
    sb.push_back(e);
  endtask

  task automatic pop_read(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    if (e.port_b) exp_b = e.data;
    else          exp_a = e.data;
    check({tag, "_dout_a"}, dout_a, exp_a);
    check({tag, "_dout_b"}, dout_b, exp_b);
  endtask

  task automatic wait_busy(input string tag);
    int t = 0;
    while (!busy && t < 20) begin tick(); t++; end
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
  endtask

  task automatic count_busy(input string tag, input int lat);
    int c = 0;
    while (busy && c < 50) begin c++; tick(); end
    check({tag, "_busy_len"}, 32'(c), 32'(lat));
  endtask

  task automatic drive(input kind_e k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr    = a;
    din     = d;
    mask    = m;
    read_a  = (k == K_RA);
    read_b  = (k == K_RB);
    write   = (k == K_WR);
    refresh = (k == K_RF);
  endtask

  task automatic clear_reqs();
    read_a = 0; read_b = 0; write = 0; refresh = 0;
  endtask

  task automatic run_op(input string tag, input kind_e k, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input int lat);
    drive(k, a, d, m);
    if (k == K_WR) model_write(a, d, m);
    if (k == K_RA || k == K_RB) push_read(k == K_RB, a);
    wait_busy(tag);
    clear_reqs();
    count_busy(tag, lat);
    if (k == K_RA || k == K_RB) pop_read(tag);
  endtask

  task automatic wait_init(input string tag);
    int c = 0;
    while (busy && c < 100) begin tick(); c++; end
    check({tag, "_init_len"}, 32'(c), 32'd16);
    check({tag, "_init_done"}, 32'(mem_initialized), 32'd1);
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    clear_reqs();
    addr = '0; din = '0; mask = '0;
    exp_a = '0; exp_b = '0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_init", 32'(mem_initialized), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_dout_a", dout_a, 32'd0);
    check("rst_dout_b", dout_b, 32'd0);
    rst = 1'b0;
    wait_init("init");
    check("init_fail", 32'(fail), 32'd0);

    run_op("wr_full",   K_WR, 32'h40, 32'hDEADBEEF, 4'h0, 1);
    run_op("rd_full",   K_RA, 32'h40, 32'h0, 4'h0, 2);
    check("rd_full_val", dout_a, 32'hDEADBEEF);
    run_op("wr_masked", K_WR, 32'h40, 32'h11223344, 4'b1010, 1);
    run_op("rd_masked", K_RA, 32'h40, 32'h0, 4'h0, 2);
    check("rd_masked_val", dout_a, 32'hDE22BE44);
    run_op("wr_nomask", K_WR, 32'h40, 32'h0, 4'hF, 1);
    run_op("rd_nomask", K_RB, 32'h40, 32'h0, 4'h0, 2);
    check("rd_nomask_val", dout_b, 32'hDE22BE44);

    // write and read_a together: write first, held read follows after the DONE cycle
    drive(K_WR, 32'h80, 32'hCAFEF00D, 4'h0);
    read_a = 1'b1;
    model_write(32'h80, 32'hCAFEF00D, 4'h0);
    push_read(1'b0, 32'h80);
    wait_busy("pri_wr");
    write = 1'b0;
    count_busy("pri_wr", 1);
    gap = 0;
    while (!busy && gap < 10) begin gap++; tick(); end
    check("pri_gap", 32'(gap), 32'd2);
    read_a = 1'b0;
    count_busy("pri_rd", 2);
    pop_read("pri_rd");
    run_op("rd_b_80", K_RB, 32'h80, 32'h0, 4'h0, 2);

    run_op("ref", K_RF, 32'h40, 32'h12345678, 4'h0, 4);
    run_op("rd_after_ref", K_RA, 32'h40, 32'h0, 4'h0, 2);

    repeat (300) tick();
    run_op("ref_300", K_RF, 32'h0, 32'h0, 4'h0, 4);
    check("ref_periodic_fail", 32'(fail), 32'd0);
    repeat (410) tick();
    check("ref_late_fail", 32'(fail), 32'(LATE_REF_FAIL));

    run_op("rd_oob", K_RA, 32'h0001_0040, 32'h0, 4'h0, 2);
    check("oob_fail", 32'(fail), 32'd1);
    run_op("rd_after_oob", K_RB, 32'h80, 32'h0, 4'h0, 2);
    check("oob_sticky", 32'(fail), 32'd1);

    // reset between acceptance and the write edge drops the write
    drive(K_WR, 32'h40, 32'h55555555, 4'h0);
    wait_busy("wr_drop");
    rst = 1'b1;
    clear_reqs();
    tick();
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_fail", 32'(fail), 32'd0);
    check("mid_rst_init", 32'(mem_initialized), 32'd0);
    exp_a = '0;
    exp_b = '0;
    rst = 1'b0;
    wait_init("reinit");
    run_op("rd_dropped", K_RA, 32'h40, 32'h0, 4'h0, 2);
    check("rd_dropped_val", dout_a, 32'hDE22BE44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
